// File: rtl/ipif_reg_bank_pkg.sv
// Shared types and helpers for the IPIF register bank: FSM encoding, access classes, log2.
// Pure declarations; no timing or flow control of its own.
package ipif_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_WO  = 2'd0,
    CLS_RW  = 2'd1,
    CLS_RO  = 2'd2,
    CLS_BAD = 2'd3
  } acc_cls_t;

  localparam int BYTE_W = 8;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Word index -> region, in map order WO, RW, RO, then out of range.
  function automatic acc_cls_t idx_class(input int idx, input int n_wo,
                                         input int n_rw, input int n_ro);
    acc_cls_t c;
    if (idx < n_wo)                    c = CLS_WO;
    else if (idx < n_wo + n_rw)        c = CLS_RW;
    else if (idx < n_wo + n_rw + n_ro) c = CLS_RO;
    else                               c = CLS_BAD;
    return c;
  endfunction

endpackage

// File: rtl/ipif_reg_bank_if.sv
// IPIF slave bus bundle between the AXI-Lite IPIF and the register bank.
// Request held by master until one ack pulse; no further backpressure.
interface ipif_reg_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   Bus2IP_Addr;
  logic                Bus2IP_CS;
  logic                Bus2IP_RNW;
  logic [DATA_W-1:0]   Bus2IP_Data;
  logic [DATA_W/8-1:0] Bus2IP_BE;
  logic [DATA_W-1:0]   IP2Bus_Data;
  logic                IP2Bus_RdAck;
  logic                IP2Bus_WrAck;
  logic                IP2Bus_Error;

  modport master (
    output Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
    input  IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );

  modport slave (
    input  Bus2IP_Addr, Bus2IP_CS, Bus2IP_RNW, Bus2IP_Data, Bus2IP_BE,
    output IP2Bus_Data, IP2Bus_RdAck, IP2Bus_WrAck, IP2Bus_Error
  );
endinterface

// File: rtl/ipif_reg_bank_be_merge.sv
// Byte-lane write merge: each lane takes the new byte when its enable is set.
// Combinational, zero latency; no flow control.
module ipif_be_merge
  import ipif_reg_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0]        i_old,
  input  logic [DW-1:0]        i_new,
  input  logic [DW/BYTE_W-1:0] i_be,
  output logic [DW-1:0]        o_merged
);
  for (genvar b = 0; b < DW / BYTE_W; b++) begin : g_lane
    assign o_merged[b*BYTE_W +: BYTE_W] = i_be[b] ? i_new[b*BYTE_W +: BYTE_W]
                                                  : i_old[b*BYTE_W +: BYTE_W];
  end
endmodule

// File: rtl/ipif_reg_bank.sv
// WO/RW/RO software register bank on the IPIF bus with byte enables, strobes and error acks.
// Ack, data, update and strobes one cycle after CS is sampled; one ack per CS assertion.
module ipif_reg_bank
  import ipif_reg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int NUM_WO_REGS        = 1,
  parameter int NUM_RW_REGS        = 1,
  parameter int NUM_RO_REGS        = 1,
  parameter logic [(NUM_WO_REGS+NUM_RW_REGS)*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUES = '0,
  parameter logic [NUM_RO_REGS-1:0] RO_CLR_ON_READ = '0
) (
  input  logic                                      Bus2IP_Clk,
  input  logic                                      Bus2IP_Resetn,
  ipif_reg_bank_if.slave                            ipif,
  output logic [NUM_WO_REGS*C_S_AXI_DATA_WIDTH-1:0] wo_regs,
  output logic [NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0] rw_regs,
  input  logic [NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0] ro_regs,
  output logic [NUM_WO_REGS+NUM_RW_REGS-1:0]        wr_pulse,
  output logic [NUM_RO_REGS-1:0]                    ro_rd_pulse
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int NUM_W    = NUM_WO_REGS + NUM_RW_REGS;
  localparam int TOTAL    = NUM_W + NUM_RO_REGS;
  localparam int ADDR_LSB = log2(DW / BYTE_W);
  localparam int IDX_W    = (TOTAL > 1) ? log2(TOTAL) : 1;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_rnw;
  logic [DW-1:0]         r_wdat;
  logic [DW/BYTE_W-1:0]  r_be;
  logic [NUM_W*DW-1:0]   r_regs;
  logic [DW-1:0]         r_rdata;
  logic                  r_rdack;
  logic                  r_wrack;
  logic                  r_err;
  logic [NUM_W-1:0]      r_wr_pulse;
  logic [NUM_RO_REGS-1:0] r_ro_pulse;

  logic [DW-1:0] w_old;
  logic [DW-1:0] w_ro;
  logic [DW-1:0] w_merged;
  acc_cls_t      w_cls;
  logic          w_unused;

  assign w_cls = idx_class(int'(r_idx), NUM_WO_REGS, NUM_RW_REGS, NUM_RO_REGS);

  always_comb begin
    w_old = '0;
    for (int i = 0; i < NUM_W; i++)
      if (r_idx == IDX_W'(i)) w_old = r_regs[i*DW +: DW];
  end

  always_comb begin
    w_ro = '0;
    for (int k = 0; k < NUM_RO_REGS; k++)
      if (r_idx == IDX_W'(NUM_W + k)) w_ro = ro_regs[k*DW +: DW];
  end

  ipif_be_merge #(.DW(DW)) u_merge (
    .i_old    (w_old),
    .i_new    (r_wdat),
    .i_be     (r_be),
    .o_merged (w_merged)
  );

  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_rnw      <= 1'b0;
      r_wdat     <= '0;
      r_be       <= '0;
      r_regs     <= RESET_VALUES;
      r_rdata    <= '0;
      r_rdack    <= 1'b0;
      r_wrack    <= 1'b0;
      r_err      <= 1'b0;
      r_wr_pulse <= '0;
      r_ro_pulse <= '0;
    end else begin
      r_rdack    <= 1'b0;
      r_wrack    <= 1'b0;
      r_err      <= 1'b0;
      r_wr_pulse <= '0;
      r_ro_pulse <= '0;
      case (r_state)
        IDLE: if (ipif.Bus2IP_CS) begin
          r_idx   <= ipif.Bus2IP_Addr[ADDR_LSB +: IDX_W];
          r_rnw   <= ipif.Bus2IP_RNW;
          r_wdat  <= ipif.Bus2IP_Data;
          r_be    <= ipif.Bus2IP_BE;
          r_state <= ACK;
        end
        ACK: begin
          r_state <= HOLD;
          if (r_rnw) begin
            r_rdack <= 1'b1;
            r_err   <= (w_cls == CLS_WO) || (w_cls == CLS_BAD);
            r_rdata <= (w_cls == CLS_RW) ? w_old :
                       (w_cls == CLS_RO) ? w_ro  : '0;
            // Strobe goes out for every RO read; the counter owner decides whether to clear.
            for (int k = 0; k < NUM_RO_REGS; k++)
              if (r_idx == IDX_W'(NUM_W + k)) r_ro_pulse[k] <= 1'b1;
          end else begin
            r_wrack <= 1'b1;
            r_err   <= (w_cls == CLS_RO) || (w_cls == CLS_BAD);
            for (int i = 0; i < NUM_W; i++)
              if (r_idx == IDX_W'(i)) begin
                r_regs[i*DW +: DW] <= w_merged;
                r_wr_pulse[i]      <= 1'b1;
              end
          end
        end
        HOLD: if (!ipif.Bus2IP_CS) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ipif.IP2Bus_Data  = r_rdata;
  assign ipif.IP2Bus_RdAck = r_rdack;
  assign ipif.IP2Bus_WrAck = r_wrack;
  assign ipif.IP2Bus_Error = r_err;
  assign wo_regs           = r_regs[NUM_WO_REGS*DW-1:0];
  assign rw_regs           = r_regs[NUM_W*DW-1:NUM_WO_REGS*DW];
  assign wr_pulse          = r_wr_pulse;
  assign ro_rd_pulse       = r_ro_pulse;

  // Upper address bits are don't-care; clear-on-read policy lives with the counter owner.
  assign w_unused = ^{ipif.Bus2IP_Addr, RO_CLR_ON_READ};
endmodule

// File: tb/tb_ipif_reg_bank.sv
// Directed bench for ipif_reg_bank: WO=1, RW=1, RO=1, 32-bit bus.
module tb_ipif_reg_bank;
  logic        clk;
  logic        rst_n;
  logic [31:0] wo_regs;
  logic [31:0] rw_regs;
  logic [31:0] ro_regs;
  logic [1:0]  wr_pulse;
  logic [0:0]  ro_rd_pulse;

  int total = 0;
  int bad   = 0;

  ipif_reg_bank_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  ipif_reg_bank #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (32),
    .NUM_WO_REGS        (1),
    .NUM_RW_REGS        (1),
    .NUM_RO_REGS        (1),
    .RESET_VALUES       ({32'hCAFE0001, 32'h000000FF}),
    .RO_CLR_ON_READ     (1'b1)
  ) dut (
    .Bus2IP_Clk    (clk),
    .Bus2IP_Resetn (rst_n),
    .ipif          (bus.slave),
    .wo_regs       (wo_regs),
    .rw_regs       (rw_regs),
    .ro_regs       (ro_regs),
    .wr_pulse      (wr_pulse),
    .ro_rd_pulse   (ro_rd_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One access: returns bus/strobe values one cycle after CS is sampled,
  // plus OR of acks/strobes/error seen the cycle before and the cycle after.
  task automatic access(input logic rnw, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, output logic [31:0] o_dat, output logic o_rd,
                        output logic o_wr, output logic o_err, output logic [1:0] o_wp,
                        output logic o_rp, output logic early, output logic late);
    bus.Bus2IP_Addr = addr;
    bus.Bus2IP_RNW  = rnw;
    bus.Bus2IP_Data = data;
    bus.Bus2IP_BE   = be;
    bus.Bus2IP_CS   = 1'b1;
    @(posedge clk); #1;
    early = bus.IP2Bus_RdAck | bus.IP2Bus_WrAck | bus.IP2Bus_Error | (|wr_pulse) | ro_rd_pulse[0];
    @(posedge clk); #1;
    o_dat = bus.IP2Bus_Data;
    o_rd  = bus.IP2Bus_RdAck;
    o_wr  = bus.IP2Bus_WrAck;
    o_err = bus.IP2Bus_Error;
    o_wp  = wr_pulse;
    o_rp  = ro_rd_pulse[0];
    bus.Bus2IP_CS   = 1'b0;
    bus.Bus2IP_Data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    late = bus.IP2Bus_RdAck | bus.IP2Bus_WrAck | bus.IP2Bus_Error | (|wr_pulse) | ro_rd_pulse[0];
  endtask

  initial begin
    logic [31:0] d;
    logic        rd, wr, er, rp, ea, la;
    logic [1:0]  wp;
    int          n_ack, n_wp;

    rst_n = 1'b0;
    bus.Bus2IP_Addr = '0;
    bus.Bus2IP_RNW  = 1'b0;
    bus.Bus2IP_Data = '0;
    bus.Bus2IP_BE   = '0;
    bus.Bus2IP_CS   = 1'b0;
    ro_regs         = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wo",    wo_regs, 32'h000000FF);
    chk("rst_rw",    rw_regs, 32'hCAFE0001);
    chk("rst_acks",  {29'd0, bus.IP2Bus_RdAck, bus.IP2Bus_WrAck, bus.IP2Bus_Error}, 32'd0);
    chk("rst_data",  bus.IP2Bus_Data, 32'd0);
    chk("rst_pulse", {29'd0, wr_pulse, ro_rd_pulse}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clear RW, then partial-lane write
    access(1'b0, 32'h4, 32'h0, 4'hF, d, rd, wr, er, wp, rp, ea, la);
    chk("rw_clear", rw_regs, 32'h0);
    access(1'b0, 32'h4, 32'hAABBCCDD, 4'b0101, d, rd, wr, er, wp, rp, ea, la);
    chk("be_rw_val",   rw_regs, 32'h00BB00DD);
    chk("be_rw_ack",   {29'd0, rd, wr, er}, 32'b010);
    chk("be_rw_pulse", {30'd0, wp}, 32'b10);
    chk("be_rw_early", {31'd0, ea}, 32'd0);
    chk("be_rw_late",  {31'd0, la}, 32'd0);
    access(1'b1, 32'h4, 32'h0, 4'hF, d, rd, wr, er, wp, rp, ea, la);
    chk("rd_rw_data", d, 32'h00BB00DD);
    chk("rd_rw_ack",  {29'd0, rd, wr, er}, 32'b100);

    // WO byte-enable write and BE=0 write
    access(1'b0, 32'h0, 32'h11223344, 4'b1100, d, rd, wr, er, wp, rp, ea, la);
    chk("wo_be_val",   wo_regs, 32'h112200FF);
    chk("wo_be_pulse", {30'd0, wp}, 32'b01);
    access(1'b0, 32'h0, 32'hFFFFFFFF, 4'b0000, d, rd, wr, er, wp, rp, ea, la);
    chk("be0_val",   wo_regs, 32'h112200FF);
    chk("be0_ack",   {29'd0, rd, wr, er}, 32'b010);
    chk("be0_pulse", {30'd0, wp}, 32'b01);

    // CS held high for 10 cycles yields a single ack
    bus.Bus2IP_Addr = 32'h4;
    bus.Bus2IP_RNW  = 1'b0;
    bus.Bus2IP_Data = 32'h5A5A5A5A;
    bus.Bus2IP_BE   = 4'hF;
    bus.Bus2IP_CS   = 1'b1;
    n_ack = 0;
    n_wp  = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.IP2Bus_WrAck) n_ack++;
      if (wr_pulse[1]) n_wp++;
    end
    bus.Bus2IP_CS = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.IP2Bus_WrAck) n_ack++;
    end
    chk("hold_acks",   n_ack, 32'd1);
    chk("hold_pulses", n_wp,  32'd1);
    chk("hold_val",    rw_regs, 32'h5A5A5A5A);

    // RO read
    access(1'b1, 32'h8, 32'h0, 4'hF, d, rd, wr, er, wp, rp, ea, la);
    chk("ro_rd_data",  d, 32'h12345678);
    chk("ro_rd_ack",   {29'd0, rd, wr, er}, 32'b100);
    chk("ro_rd_pulse", {31'd0, rp}, 32'd1);
    chk("ro_rd_late",  {31'd0, la}, 32'd0);

    // Write to RO index: error, nothing changes, read data held
    access(1'b0, 32'h8, 32'h99999999, 4'hF, d, rd, wr, er, wp, rp, ea, la);
    chk("ro_wr_ack",   {29'd0, rd, wr, er}, 32'b011);
    chk("ro_wr_pulse", {29'd0, wp, rp}, 32'd0);
    chk("ro_wr_regs",  rw_regs ^ wo_regs, 32'h5A5A5A5A ^ 32'h112200FF);
    chk("data_held",   bus.IP2Bus_Data, 32'h12345678);

    // Read of WO index and out-of-range index
    access(1'b1, 32'h0, 32'h0, 4'hF, d, rd, wr, er, wp, rp, ea, la);
    chk("wo_rd_ack",  {29'd0, rd, wr, er}, 32'b101);
    chk("wo_rd_data", d, 32'h0);
    access(1'b1, 32'hC, 32'h0, 4'hF, d, rd, wr, er, wp, rp, ea, la);
    chk("bad_rd_ack",   {29'd0, rd, wr, er}, 32'b101);
    chk("bad_rd_data",  d, 32'h0);
    chk("bad_rd_pulse", {31'd0, rp}, 32'd0);

    // Upper address bits ignored
    ro_regs = 32'h0BAD_F00D;
    access(1'b1, 32'h0000_1004, 32'h0, 4'hF, d, rd, wr, er, wp, rp, ea, la);
    chk("alias_data", d, 32'h5A5A5A5A);
    chk("alias_ack",  {29'd0, rd, wr, er}, 32'b100);

    // Reset asserted while in ACK: access dropped, held CS starts a new one
    bus.Bus2IP_Addr = 32'h4;
    bus.Bus2IP_RNW  = 1'b0;
    bus.Bus2IP_Data = 32'h77777777;
    bus.Bus2IP_BE   = 4'hF;
    bus.Bus2IP_CS   = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_rw", rw_regs, 32'hCAFE0001);
    chk("mrst_wo", wo_regs, 32'h000000FF);
    @(posedge clk); #1;
    chk("mrst_noack", {28'd0, bus.IP2Bus_WrAck, bus.IP2Bus_RdAck, wr_pulse}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_idle", {31'd0, bus.IP2Bus_WrAck}, 32'd0);
    @(posedge clk); #1;
    chk("mrst_reack", {30'd0, bus.IP2Bus_WrAck, wr_pulse[1]}, 32'b11);
    chk("mrst_val",   rw_regs, 32'h77777777);
    bus.Bus2IP_CS = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ipif_reg_bank.md
# ipif_reg_bank

Parametrised software register bank on the AXI-Lite IPIF bus for NetFPGA-10G pcores. It is the successor to the project's basic WO/RW/RO register file and adds the following:
- byte-enable writes
- per-register reset values
- write and read strobes to the datapath
- clear-on-read signalling for RO counters
- error response on illegal accesses
- a one-ack-per-access handshake FSM

It sits between the IPIF slave and core logic such as the AES key and control registers.

## Interface
- C_S_AXI_DATA_WIDTH, 32, bus and register width; must be a multiple of 8.
- C_S_AXI_ADDR_WIDTH, 32, bus address width.
- NUM_WO_REGS, 1, registers written by SW, read by HW only.
- NUM_RW_REGS, 1, registers written by SW, read by HW and SW.
- NUM_RO_REGS, 1, registers driven by HW, read by SW only.
- RESET_VALUES, 0, packed (NUM_WO_REGS+NUM_RW_REGS)*DATA_WIDTH reset image; register i occupies slice i.
- RO_CLR_ON_READ, 0, NUM_RO_REGS-bit mask; bit k set means RO reg k is clear-on-read.

Ports:
- Bus2IP_Clk  in  1  single clock.
- Bus2IP_Resetn  in  1  asynchronous active-low reset.
- Bus2IP_Addr  in  ADDR_WIDTH  byte address.
- Bus2IP_CS  in  1  access request; held until ack.
- Bus2IP_RNW  in  1  1 = read, 0 = write.
- Bus2IP_Data  in  DATA_WIDTH  write data.
- Bus2IP_BE  in  DATA_WIDTH/8  byte enables.
- IP2Bus_Data  out  DATA_WIDTH  read data.
- IP2Bus_RdAck  out  1  read completion pulse.
- IP2Bus_WrAck  out  1  write completion pulse.
- IP2Bus_Error  out  1  error, valid only with an ack.
- wo_regs  out  NUM_WO_REGS*DATA_WIDTH  WO contents.
- rw_regs  out  NUM_RW_REGS*DATA_WIDTH  RW contents.
- ro_regs  in  NUM_RO_REGS*DATA_WIDTH  HW status values.
- wr_pulse  out  NUM_WO_REGS+NUM_RW_REGS  one-cycle strobe per written register.
- ro_rd_pulse  out  NUM_RO_REGS  one-cycle strobe per RO read; the owner clears the counter if it is clear-on-read.

## Operation
Address map:
- Word index = Bus2IP_Addr[ADDR_LSB +: IDX_W], where ADDR_LSB = log2(DATA_WIDTH/8) and IDX_W = log2(TOTAL), TOTAL = NUM_WO+NUM_RW+NUM_RO.
- Index order is WO, then RW, then RO. Upper address bits are ignored.

FSM states: IDLE, ACK, HOLD.
- **IDLE:** when CS=1, latch the index and RNW, then go to ACK.
- **ACK:** assert exactly one of RdAck/WrAck for one cycle, then go to HOLD.
- **HOLD:** wait for CS=0, then return to IDLE. CS still high in HOLD never produces a second ack.

Writes:
- Index < NUM_WO+NUM_RW: per byte lane b, reg[b] <= BE[b] ? Data[b] : reg[b]. Assert wr_pulse[index] and WrAck, Error=0.
- BE=0 still acks and still pulses wr_pulse.
- Index in the RO range, or index >= TOTAL: no register change, no pulse, WrAck with Error=1.

Reads:
- RW or RO index: IP2Bus_Data = current value. For an RO index, pulse ro_rd_pulse[k] whatever the RO_CLR_ON_READ setting.
- WO index or index >= TOTAL: Data=0, RdAck with Error=1.

Held values:
- IP2Bus_Data holds its value until the next read ack.
- IP2Bus_Error is 0 whenever no ack is asserted.

## Timing
- **Reset:** asynchronous, active-low.
  - State → IDLE.
  - wo_regs/rw_regs → RESET_VALUES.
  - IP2Bus_Data, RdAck, WrAck, Error, wr_pulse, ro_rd_pulse → 0.
- **Reset mid-access:** the access is dropped with no ack and no pulse. A CS still high after release is treated as a new access.
- **Latency:**
  - CS sampled high in IDLE at edge N.
  - Ack, Error, read data, register update, wr_pulse and ro_rd_pulse are all visible after edge N+1, asserted for exactly one cycle.
- **Throughput:** minimum 3 cycles per access (IDLE→ACK→HOLD→IDLE).
- **Read data timing:** the ro_regs value is the one sampled at edge N+1. A HW change during ACK is not reflected.
- **Bus changes:** Addr, RNW and Data are latched at edge N; later changes are ignored.

## Structure
- Package ipif_reg_pkg holds:
  - the log2 function;
  - the FSM state encoding (IDLE=2'd0, ACK=2'd1, HOLD=2'd2);
  - the index-range helper constants.
- Sub-module ipif_be_merge is the byte-lane write merge (old word, new word, BE → merged word). It is instantiated per writable register or once shared on the latched index.

## Test plan
- Reset with RESET_VALUES = {32'hCAFE0001, 32'h0000_00FF} (WO=1, RW=1) → wo_regs=0x000000FF, rw_regs=0xCAFE0001, all acks 0.
- Write 0xAABBCCDD, BE=4'b0101, to RW (value 0x0) → rw_regs=0x00BB00DD; WrAck and wr_pulse[1] high one cycle, 2 cycles after CS; then read back returns 0x00BB00DD.
- CS held high 10 cycles on a write → exactly one WrAck.
- Read RO k=0 with ro_regs=0x12345678 → Data=0x12345678, RdAck=1, Error=0, ro_rd_pulse[0]=1 for one cycle.
- Illegal accesses:
  - Write to RO index → WrAck with Error=1, ro unchanged.
  - Read of WO index → RdAck with Error=1, Data=0.
  - Read of index TOTAL → RdAck with Error=1.
- Resetn pulsed low in the ACK state → no ack, registers back to RESET_VALUES, FSM in IDLE.
